// File: rtl/wait_fee_acc.sv
// -----------------------------------------------------------------------------
// wait_fee_acc : waiting-time fee accumulator for the taxi meter.
//
// Edge-detects the minute divider's square wave, counts waiting minutes in
// BCD and, after FREE_MIN free minutes, adds RATE_BCD (0.1 yuan units) to a
// BCD fee register for every further minute, strobing fee_pulse once per
// charged minute. Both counters saturate (99 minutes / 999 fee) into HOLD.
//
// Parameters:
//   FREE_MIN  free waiting minutes before charging starts (0..98)
//   RATE_BCD  charge per waiting minute, 3 BCD digits
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   waiting mode; minutes accrue only while high
//   max        in   fee ceiling reached elsewhere; freezes accrual
//   clr        in   synchronous clear at start of a new trip
//   min_pulse  in   minute square wave, one rising edge per minute
//   night      in   (only with WAIT_NIGHT_EN) doubles the per-minute charge
//   wait_min   out  elapsed waiting minutes, 2 BCD digits
//   wait_fee   out  accumulated waiting fee, 3 BCD digits
//   fee_pulse  out  one-cycle strobe per charged minute
//   sat        out  high while in HOLD
//   dbg_state  out  current FSM state (0 IDLE, 1 FREE, 2 CHARGE, 3 HOLD)
//
// Optional feature: define WAIT_NIGHT_EN to add the night surcharge input.
// -----------------------------------------------------------------------------
module wait_fee_acc #(
    parameter int          FREE_MIN = 3,
    parameter logic [11:0] RATE_BCD = 12'h010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        max,
    input  logic        clr,
    input  logic        min_pulse,
`ifdef WAIT_NIGHT_EN
    input  logic        night,
`endif
    output logic [7:0]  wait_min,
    output logic [11:0] wait_fee,
    output logic        fee_pulse,
    output logic        sat,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FREE   = 2'd1,
        S_CHARGE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // 3-digit BCD add; bit 12 is the carry out of the hundreds digit.
    function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] res;
        logic        c;
        logic [4:0]  s;
        res = '0;
        c   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            res[i*4 +: 4] = s[3:0];
        end
        res[12] = c;
        return res;
    endfunction

    // 2-digit BCD increment; the 99 case is never used (saturation wins).
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    localparam logic [7:0] FREE_BCD    = 8'(((FREE_MIN / 10) * 16) + (FREE_MIN % 10));
    localparam state_t     START_STATE = (FREE_MIN > 0) ? S_FREE : S_CHARGE;

    state_t      r_state;
    logic        r_min_d;
    logic [7:0]  r_wait_min;
    logic [11:0] r_wait_fee;
    logic        r_fee_pulse;

    state_t      w_state_eff;
    state_t      w_state_nx;
    logic [7:0]  w_min_nx;
    logic [11:0] w_fee_nx;
    logic        w_pulse_nx;
    logic        w_tick;
    logic [7:0]  w_min_inc;
    logic        w_min_full;
    logic [12:0] w_rate;
    logic [12:0] w_fee_sum;
    logic        w_fee_ovf;

    // Edges seen while en=0 or max=1 are dropped, not remembered.
    assign w_tick     = min_pulse & ~r_min_d & en & ~max;
    assign w_min_inc  = bcd_inc2(r_wait_min);
    assign w_min_full = (r_wait_min == 8'h99);

`ifdef WAIT_NIGHT_EN
    // Doubled rate kept as a BCD constant; a carry here (rate > 499) means
    // any night charge overflows the fee register.
    localparam logic [12:0] RATE_X2 = bcd_add(RATE_BCD, RATE_BCD);
    assign w_rate = night ? RATE_X2 : {1'b0, RATE_BCD};
`else
    assign w_rate = {1'b0, RATE_BCD};
`endif

    assign w_fee_sum = bcd_add(r_wait_fee, w_rate[11:0]);
    assign w_fee_ovf = w_fee_sum[12] | w_rate[12];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min_d     <= 1'b0;
            r_wait_min  <= 8'h00;
            r_wait_fee  <= 12'h000;
            r_fee_pulse <= 1'b0;
        end else begin
            r_min_d     <= min_pulse;
            r_wait_min  <= w_min_nx;
            r_wait_fee  <= w_fee_nx;
            r_fee_pulse <= w_pulse_nx;
        end
    end

    // Next-state and next-value logic. Leaving IDLE and a tick in the same
    // cycle: the tick is handled as if already in the target state.
    always_comb begin
        w_state_eff = r_state;
        if (r_state == S_IDLE && en)
            w_state_eff = START_STATE;
        w_state_nx = w_state_eff;
        w_min_nx   = r_wait_min;
        w_fee_nx   = r_wait_fee;
        w_pulse_nx = 1'b0;
        if (clr) begin
            w_state_nx = S_IDLE;
            w_min_nx   = 8'h00;
            w_fee_nx   = 12'h000;
        end else if (w_tick) begin
            case (w_state_eff)
                S_FREE: begin
                    if (w_min_full) begin
                        w_state_nx = S_HOLD;
                    end else begin
                        w_min_nx = w_min_inc;
                        if (w_min_inc == FREE_BCD)
                            w_state_nx = S_CHARGE;
                    end
                end
                S_CHARGE: begin
                    if (!w_min_full)
                        w_min_nx = w_min_inc;
                    w_pulse_nx = 1'b1;
                    w_fee_nx   = w_fee_ovf ? 12'h999 : w_fee_sum[11:0];
                    if (w_min_full || w_fee_ovf)
                        w_state_nx = S_HOLD;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs straight from registers
    always_comb begin
        wait_min  = r_wait_min;
        wait_fee  = r_wait_fee;
        fee_pulse = r_fee_pulse;
        sat       = (r_state == S_HOLD);
        dbg_state = r_state;
    end

endmodule

// File: tb/tb_wait_fee_acc.sv
// -----------------------------------------------------------------------------
// tb_wait_fee_acc : self-checking bench for wait_fee_acc.
//
// Four instances share one stimulus stream but differ in FREE_MIN/RATE_BCD:
//   0: defaults (3, 010)   1: (0, 250)   2: (0, 095)   3: (0, 001)
// A decimal reference model predicts every instance; predictions are queued
// when a minute edge is driven and popped one cycle after the edge.
// -----------------------------------------------------------------------------
module tb_wait_fee_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic max = 1'b0;
    logic clr = 1'b0;
    logic min_pulse = 1'b0;
`ifdef WAIT_NIGHT_EN
    logic night = 1'b0;
`endif

    logic [7:0]  wmin   [4];
    logic [11:0] wfee   [4];
    logic        wpulse [4];
    logic        wsat   [4];
    logic [1:0]  dstate [4];

    always #5 clk = ~clk;

`ifdef WAIT_NIGHT_EN
    wait_fee_acc dut0 (.clk(clk), .rst_n(rst_n), .en(en), .max(max), .clr(clr), .min_pulse(min_pulse), .night(night),
        .wait_min(wmin[0]), .wait_fee(wfee[0]), .fee_pulse(wpulse[0]), .sat(wsat[0]), .dbg_state(dstate[0]));
    wait_fee_acc #(.FREE_MIN(0), .RATE_BCD(12'h250)) dut1 (.clk(clk), .rst_n(rst_n), .en(en), .max(max), .clr(clr),
        .min_pulse(min_pulse), .night(night), .wait_min(wmin[1]), .wait_fee(wfee[1]), .fee_pulse(wpulse[1]), .sat(wsat[1]), .dbg_state(dstate[1]));
    wait_fee_acc #(.FREE_MIN(0), .RATE_BCD(12'h095)) dut2 (.clk(clk), .rst_n(rst_n), .en(en), .max(max), .clr(clr),
        .min_pulse(min_pulse), .night(night), .wait_min(wmin[2]), .wait_fee(wfee[2]), .fee_pulse(wpulse[2]), .sat(wsat[2]), .dbg_state(dstate[2]));
    wait_fee_acc #(.FREE_MIN(0), .RATE_BCD(12'h001)) dut3 (.clk(clk), .rst_n(rst_n), .en(en), .max(max), .clr(clr),
        .min_pulse(min_pulse), .night(night), .wait_min(wmin[3]), .wait_fee(wfee[3]), .fee_pulse(wpulse[3]), .sat(wsat[3]), .dbg_state(dstate[3]));
`else
    wait_fee_acc dut0 (.clk(clk), .rst_n(rst_n), .en(en), .max(max), .clr(clr), .min_pulse(min_pulse),
        .wait_min(wmin[0]), .wait_fee(wfee[0]), .fee_pulse(wpulse[0]), .sat(wsat[0]), .dbg_state(dstate[0]));
    wait_fee_acc #(.FREE_MIN(0), .RATE_BCD(12'h250)) dut1 (.clk(clk), .rst_n(rst_n), .en(en), .max(max), .clr(clr),
        .min_pulse(min_pulse), .wait_min(wmin[1]), .wait_fee(wfee[1]), .fee_pulse(wpulse[1]), .sat(wsat[1]), .dbg_state(dstate[1]));
    wait_fee_acc #(.FREE_MIN(0), .RATE_BCD(12'h095)) dut2 (.clk(clk), .rst_n(rst_n), .en(en), .max(max), .clr(clr),
        .min_pulse(min_pulse), .wait_min(wmin[2]), .wait_fee(wfee[2]), .fee_pulse(wpulse[2]), .sat(wsat[2]), .dbg_state(dstate[2]));
    wait_fee_acc #(.FREE_MIN(0), .RATE_BCD(12'h001)) dut3 (.clk(clk), .rst_n(rst_n), .en(en), .max(max), .clr(clr),
        .min_pulse(min_pulse), .wait_min(wmin[3]), .wait_fee(wfee[3]), .fee_pulse(wpulse[3]), .sat(wsat[3]), .dbg_state(dstate[3]));
`endif

    // Reference model, plain decimal integers
    int free_t [4] = '{3, 0, 0, 0};
    int rate_t [4] = '{10, 250, 95, 1};
    int m_min  [4];
    int m_fee  [4];
    bit m_hold [4];
    int mult = 1;

    int n_checks = 0;
    int n_errors = 0;

    // {wait_min bcd, wait_fee bcd, fee_pulse, sat}
    logic [21:0] exp_q[$];

    typedef struct {
        bit         en;
        bit         mx;
        bit         clr_first;
        int         edges;
        logic [7:0] exp_min;
        logic [11:0] exp_fee;
    } seg_t;

    seg_t tbl [8];

    function automatic logic [7:0] to_bcd2(int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [11:0] to_bcd3(int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_min[i]  = 0;
            m_fee[i]  = 0;
            m_hold[i] = 1'b0;
        end
    endtask

    task automatic model_tick(input int i, output bit pulse);
        bit charge;
        pulse = 1'b0;
        if (!m_hold[i]) begin
            charge = (m_min[i] >= free_t[i]);
            if (m_min[i] == 99) m_hold[i] = 1'b1;
            else m_min[i]++;
            if (charge) begin
                pulse = 1'b1;
                m_fee[i] += rate_t[i] * mult;
                if (m_fee[i] > 999) begin
                    m_fee[i]  = 999;
                    m_hold[i] = 1'b1;
                end
            end
        end
    endtask

    // Compare every instance with the model's current (quiescent) state
    task automatic check_model(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_min%0d", tag, i), 32'(wmin[i]), 32'(to_bcd2(m_min[i])));
            check($sformatf("%s_fee%0d", tag, i), 32'(wfee[i]), 32'(to_bcd3(m_fee[i])));
            check($sformatf("%s_pulse%0d", tag, i), 32'(wpulse[i]), 32'd0);
            check($sformatf("%s_sat%0d", tag, i), 32'(wsat[i]), 32'(m_hold[i]));
        end
    endtask

    // One minute edge: high for two cycles, low for two
    task automatic do_edge(input bit with_clr);
        bit p;
        logic [21:0] e;
        @(negedge clk);
        min_pulse = 1'b1;
        clr = with_clr;
        if (with_clr) model_clear();
        for (int i = 0; i < 4; i++) begin
            p = 1'b0;
            if (!with_clr && en && !max) model_tick(i, p);
            exp_q.push_back({to_bcd2(m_min[i]), to_bcd3(m_fee[i]), p, m_hold[i]});
        end
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("edge_min%0d", i), 32'(wmin[i]), 32'(e[21:14]));
                check($sformatf("edge_fee%0d", i), 32'(wfee[i]), 32'(e[13:2]));
                check($sformatf("edge_pulse%0d", i), 32'(wpulse[i]), 32'(e[1]));
                check($sformatf("edge_sat%0d", i), 32'(wsat[i]), 32'(e[0]));
                if (with_clr) check($sformatf("clr_state%0d", i), 32'(dstate[i]), 32'd0);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("pulse_width%0d", i), 32'(wpulse[i]), 32'd0);
        min_pulse = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    initial begin
        tbl[0] = '{en: 1'b0, mx: 1'b0, clr_first: 1'b1, edges: 4, exp_min: 8'h00, exp_fee: 12'h000};
        tbl[1] = '{en: 1'b1, mx: 1'b0, clr_first: 1'b0, edges: 5, exp_min: 8'h05, exp_fee: 12'h020};
        tbl[2] = '{en: 1'b1, mx: 1'b0, clr_first: 1'b1, edges: 2, exp_min: 8'h02, exp_fee: 12'h000};
        tbl[3] = '{en: 1'b0, mx: 1'b0, clr_first: 1'b0, edges: 3, exp_min: 8'h02, exp_fee: 12'h000};
        tbl[4] = '{en: 1'b1, mx: 1'b0, clr_first: 1'b0, edges: 2, exp_min: 8'h04, exp_fee: 12'h010};
        tbl[5] = '{en: 1'b1, mx: 1'b0, clr_first: 1'b1, edges: 2, exp_min: 8'h02, exp_fee: 12'h000};
        tbl[6] = '{en: 1'b1, mx: 1'b1, clr_first: 1'b0, edges: 3, exp_min: 8'h02, exp_fee: 12'h000};
        tbl[7] = '{en: 1'b1, mx: 1'b0, clr_first: 1'b0, edges: 2, exp_min: 8'h04, exp_fee: 12'h010};

        model_clear();
        repeat (3) @(negedge clk);
        check_model("reset");
        for (int i = 0; i < 4; i++) check($sformatf("reset_state%0d", i), 32'(dstate[i]), 32'd0);
        rst_n = 1'b1;

        // Table-driven segments on the default-parameter instance
        for (int s = 0; s < 8; s++) begin
            if (tbl[s].clr_first) do_clr();
            en  = tbl[s].en;
            max = tbl[s].mx;
            repeat (tbl[s].edges) do_edge(1'b0);
            check($sformatf("seg%0d_min", s), 32'(wmin[0]), 32'(tbl[s].exp_min));
            check($sformatf("seg%0d_fee", s), 32'(wfee[0]), 32'(tbl[s].exp_fee));
        end
        max = 1'b0;

        // Fee saturation at 999 on instance 1 (rate 250, no free minutes)
        do_clr();
        en = 1'b1;
        repeat (3) do_edge(1'b0);
        check("sat250_fee3", 32'(wfee[1]), 32'h750);
        check("sat250_sat3", 32'(wsat[1]), 32'd0);
        do_edge(1'b0);
        check("sat250_fee4", 32'(wfee[1]), 32'h999);
        check("sat250_sat4", 32'(wsat[1]), 32'd1);
        do_edge(1'b0);
        check("sat250_min5", 32'(wmin[1]), 32'h04);
        check("sat250_fee5", 32'(wfee[1]), 32'h999);

        // BCD digit carry on instance 2 (rate 095)
        do_clr();
        repeat (2) do_edge(1'b0);
        check("carry095_fee", 32'(wfee[2]), 32'h190);

        // Minute saturation at 99 on instance 3 (rate 001)
        do_clr();
        repeat (99) do_edge(1'b0);
        check("min99_min", 32'(wmin[3]), 32'h99);
        check("min99_fee", 32'(wfee[3]), 32'h099);
        check("min99_sat", 32'(wsat[3]), 32'd0);
        do_edge(1'b0);
        check("min100_min", 32'(wmin[3]), 32'h99);
        check("min100_fee", 32'(wfee[3]), 32'h100);
        check("min100_sat", 32'(wsat[3]), 32'd1);

        // clr coinciding with a minute edge while charging
        do_clr();
        repeat (5) do_edge(1'b0);
        check("pre_clr_state", 32'(dstate[0]), 32'd2);
        do_edge(1'b1);
        check("post_clr_fee", 32'(wfee[0]), 32'h000);

        // Asynchronous reset in the middle of a run
        repeat (3) do_edge(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef WAIT_NIGHT_EN
        // Night surcharge doubles the per-minute rate
        do_clr();
        night = 1'b1;
        mult = 2;
        repeat (4) do_edge(1'b0);
        check("night_fee", 32'(wfee[0]), 32'h020);
        night = 1'b0;
        mult = 1;
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wait_fee_acc.md
# wait_fee_acc

Waiting-time fee accumulator for the taxi meter. It sits directly downstream of the minute divider: it edge-detects the divider's `min_pulse` square wave (one rising edge per elapsed minute) and counts waiting minutes in BCD. After a configurable number of free minutes it adds a per-minute waiting charge to a BCD fee register and strobes `fee_pulse` for each charged minute, which `fee_total` consumes.

## Interface
- `FREE_MIN`, default 3: number of free waiting minutes before charging starts; legal range 0..98.
- `RATE_BCD`, default 12'h010: charge per waiting minute, 3 BCD digits, in units of 0.1 yuan (12'h010 = 1.0 yuan); each digit must be 0..9.
- `clk`  input  1: system clock (50 MHz).
- `rst_n`  input  1: asynchronous active-low reset.
- `en`  input  1: waiting mode (meter running, vehicle stopped); minutes accrue only while high.
- `max`  input  1: fee ceiling reached, from `fee_total`; freezes accrual while high.
- `clr`  input  1: synchronous clear at start of a new trip.
- `min_pulse`  input  1: minute square wave from the divider; each rising edge = 1 minute.
- `wait_min`  output  8: elapsed waiting minutes, 2 BCD digits, 00..99.
- `wait_fee`  output  12: accumulated waiting fee, 3 BCD digits, 000..999.
- `fee_pulse`  output  1: one-cycle strobe for each charged minute.
- `sat`  output  1: high while in HOLD (minute or fee counter saturated).

## Operation
- Edge detect: register `min_d` <= `min_pulse` (reset 0). `tick` = `min_pulse & ~min_d & en & ~max`. `min_d` updates every cycle regardless of `en`/`max`. Edges occurring while `en`=0 or `max`=1 are lost, not deferred.
- The FSM has four states: IDLE, FREE, CHARGE and HOLD.
  - IDLE: counters are zero. On `en`=1, go to FREE if FREE_MIN>0, else go to CHARGE. A tick in the same cycle is processed as in the target state.
  - FREE: on tick, `wait_min`+1 (BCD). If the new value equals FREE_MIN, go to CHARGE. No fee is added.
  - CHARGE: on tick, `wait_min`+1 and `wait_fee`+RATE_BCD (BCD add with per-digit +6 correction), and `fee_pulse`=1 for that cycle.
  - HOLD: ticks are ignored and all values are frozen. Exit is only by `clr` or `rst_n`.
- Saturation:
  - A tick with `wait_min`=99 keeps 99 and moves the FSM to HOLD. In CHARGE, the fee is still added for that tick.
  - If `wait_fee`+RATE exceeds 999, `wait_fee`=999, `fee_pulse`=1 for that tick, and the FSM moves to HOLD.
  - If both conditions occur on one tick, both apply.
- `en` falling in FREE or CHARGE: the state and values are held, and accrual resumes when `en` returns.
- Priority: `rst_n` > `clr` > tick. `clr`=1 means IDLE and all outputs zero on the next edge; a tick in the same cycle is discarded. `min_d` still updates.
- `sat` = (state == HOLD).

## Timing
- Reset values: `wait_min`=8'h00, `wait_fee`=12'h000, `fee_pulse`=0, `sat`=0, state IDLE, `min_d`=0.
- Latency: `min_pulse` is first sampled high at clock edge N with `min_d`=0. Updated `wait_min`/`wait_fee` and `fee_pulse`=1 are visible after edge N (one cycle), and `fee_pulse` deasserts after edge N+1.
- At most one tick per `min_pulse` rising edge. Bench spacing of 2 or more cycles between edges must be handled.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Asserting `rst_n` mid-operation clears everything asynchronously, with no partial BCD state left.

## Configuration
- `WAIT_NIGHT_EN` defined:
  - Adds input `night` (1 bit).
  - While `night`=1, each charged tick adds 2×RATE_BCD. The doubled constant is computed as a BCD sum, and saturation at 999 applies as usual.
- `WAIT_NIGHT_EN` undefined: no `night` port, and the charge is always RATE_BCD.

## Test plan
- Reset, then idle with `min_pulse` toggling and `en`=0 -> `wait_min`=00, `wait_fee`=000, `fee_pulse` never high, `sat`=0.
- Defaults, `en`=1, 5 rising edges -> `wait_min`=05, `wait_fee`=020, exactly 2 `fee_pulse` strobes (minutes 4 and 5), each one cycle wide and one cycle after the edge.
- `en`=1, 2 edges, then `en`=0 across 3 edges, then `en`=1 with 2 edges -> `wait_min`=04, `wait_fee`=010. Repeat with `max`=1 instead of `en`=0 -> same result.
- FREE_MIN=0, RATE_BCD=12'h250, 5 edges -> `wait_fee` 250, 500, 750, 999; `sat`=1 after the 4th edge; 5th edge gives no pulse and `wait_min` stays 04.
- BCD carry: FREE_MIN=0, RATE_BCD=12'h095, 2 edges -> `wait_fee`=190. 99 edges with RATE_BCD=12'h001 -> `wait_min`=99, `wait_fee`=099; the 100th edge gives `sat`=1, `wait_min`=99, `wait_fee`=100.
- `clr` asserted in the same cycle as a `min_pulse` rising edge during CHARGE -> all outputs zero next cycle, no `fee_pulse`, state IDLE. With `WAIT_NIGHT_EN` and `night`=1, defaults, 4 edges -> `wait_fee`=020.
